// File: rtl/arb_pkg.sv
// Shared definitions for the N-way arbitrating multiplexer: the arbitration
// policy selector and the channel-index width helper.
package arb_pkg;

    // Arbitration policy: lowest index always wins, or rotating priority.
    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int sel_w(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : arb_pkg

// File: rtl/rr_grant.sv
// Combinational grant generator. The request vector is duplicated into a
// double-width word whose lower copy has every index below ptr masked off;
// the lowest set bit of that word is the first requester at or after ptr,
// with the upper copy supplying the wrap-around back to channel 0.
// In fixed-priority mode nothing is masked, so the lowest requester wins.
module rr_grant
    import arb_pkg::*;
#(
    parameter int        N    = 3,
    parameter arb_mode_e MODE = ARB_RR,
    localparam int       SELW = sel_w(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx
);

    logic [2*N-1:0] dbl_req;

    // Build the double-width request word with the rotating mask applied.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        dbl_req = {req, req};
        for (int i = 0; i < N; i++) begin
            if (MODE == ARB_RR && i < int'(ptr)) begin
                dbl_req[i] = 1'b0;
            end
        end
    end

    // Priority-encode the lowest set bit and fold it back into 0..N-1.
    always_comb begin
        int  pos;
        int  chan;
        logic found;
        pos   = 0;
        chan  = 0;
        found = 1'b0;
        grant = '0;
        idx   = '0;
        // Scanning downwards leaves the lowest set position in pos.
        for (int j = 2*N-1; j >= 0; j--) begin
            if (dbl_req[j]) begin
                found = 1'b1;
                pos   = j;
            end
        end
        if (found) begin
            chan        = (pos >= N) ? pos - N : pos;
            grant[chan] = 1'b1;
            idx         = SELW'(chan);
        end
    end

endmodule : rr_grant

// File: rtl/arb_mux_n.sv
// N-way registered arbitrating multiplexer. One channel is granted per cycle
// whenever the one-entry output register has space (empty, or being drained
// on this edge); the winner's data and index are captured into that register.
module arb_mux_n
    import arb_pkg::*;
#(
    parameter int        N    = 3,
    parameter int        W    = 32,
    parameter arb_mode_e MODE = ARB_RR,
    localparam int       SELW = sel_w(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_sel,
    input  logic            out_ready
);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] next_ptr;
    logic [N-1:0]    grant;
    logic [SELW-1:0] win_idx;
    logic [W-1:0]    win_data;
    logic            space;
    logic            xfer;

    rr_grant #(
        .N    (N),
        .MODE (MODE)
    ) u_grant (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    // The register can accept a new item if empty or if it drains this edge.
    assign space    = ~out_valid | out_ready;
    assign in_ready = grant & {N{space}};
    assign xfer     = |(in_valid & in_ready);

    // AND-OR mux of the granted channel's data; grant is one-hot or zero.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                win_data = win_data | in_data[i*W +: W];
            end
        end
    end

    // Priority moves to the channel after the winner, wrapping at N-1.
    always_comb begin
        next_ptr = '0;
        if (MODE == ARB_RR && int'(win_idx) != N-1) begin
            next_ptr = win_idx + SELW'(1);
        end
    end

    // Output register and priority pointer: load on a transfer, empty on an idle drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_sel   <= win_idx;
            ptr       <= next_ptr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : arb_mux_n

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n: a round-robin and a fixed-priority instance
// share the same stimulus; expected values are hand-computed.
module tb_arb_mux_n;
    import arb_pkg::*;

    localparam int N    = 3;
    localparam int W    = 32;
    localparam int SELW = sel_w(N);

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic            out_ready;

    logic [N-1:0]    rr_in_ready;
    logic            rr_out_valid;
    logic [W-1:0]    rr_out_data;
    logic [SELW-1:0] rr_out_sel;

    logic [N-1:0]    fx_in_ready;
    logic            fx_out_valid;
    logic [W-1:0]    fx_out_data;
    logic [SELW-1:0] fx_out_sel;

    int total = 0;
    int bad   = 0;

    arb_mux_n #(.N(N), .W(W), .MODE(ARB_RR)) u_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rr_in_ready),
        .out_valid (rr_out_valid),
        .out_data  (rr_out_data),
        .out_sel   (rr_out_sel),
        .out_ready (out_ready)
    );

    arb_mux_n #(.N(N), .W(W), .MODE(ARB_FIXED)) u_fx (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (fx_in_ready),
        .out_valid (fx_out_valid),
        .out_data  (fx_out_data),
        .out_sel   (fx_out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and step just past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_sel [6];
        exp_sel = '{0, 1, 2, 0, 1, 2};

        reset_n   = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;

        // 1. Reset held with toggling inputs.
        for (int i = 0; i < 4; i++) begin
            in_valid  = N'($urandom);
            in_data   = {$urandom, $urandom, $urandom};
            out_ready = ~out_ready;
            tick();
            check("rst_valid", rr_out_valid, 0);
            check("rst_sel",   rr_out_sel,   0);
            check("rst_data",  rr_out_data,  0);
        end
        in_valid  = 3'b101;
        out_ready = 1'b1;
        #1;
        check("rst_rdy_rr", rr_in_ready, 3'b001);
        check("rst_rdy_fx", fx_in_ready, 3'b001);

        reset_n  = 1'b1;
        in_valid = '0;
        in_data  = {32'hC, 32'hB, 32'hA};
        tick();
        check("idle_valid", rr_out_valid, 0);

        in_valid = 3'b100;
        #1;
        check("ch2_rdy", rr_in_ready, 3'b100);
        tick();
        check("ch2_valid", rr_out_valid, 1);
        check("ch2_sel",   rr_out_sel,   2);
        check("ch2_data",  rr_out_data,  32'hC);
        check("ch2_sel_fx", fx_out_sel,  2);

        // 2./3. All channels valid: rotation for RR, channel 0 forever for fixed.
        in_valid = 3'b111;
        #1;
        check("rr_rdy0", rr_in_ready, 3'b001);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_valid", rr_out_valid, 1);
            check("rr_sel",   rr_out_sel,   exp_sel[i]);
            check("rr_data",  rr_out_data,  32'hA + exp_sel[i]);
            check("rr_rdy",   rr_in_ready,  3'b001 << ((exp_sel[i] + 1) % 3));
            check("fx_sel",   fx_out_sel,   0);
            check("fx_data",  fx_out_data,  32'hA);
            check("fx_rdy",   fx_in_ready,  3'b001);
        end
        tick();
        check("pre_bp_sel",  rr_out_sel,  0);
        check("pre_bp_data", rr_out_data, 32'hA);

        // 4. Backpressure with channels 1 and 2 pending; pointer sits at 1.
        in_valid  = 3'b110;
        out_ready = 1'b0;
        #1;
        check("bp_rdy0", rr_in_ready, 3'b000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", rr_out_valid, 1);
            check("bp_sel",   rr_out_sel,   0);
            check("bp_data",  rr_out_data,  32'hA);
            check("bp_rdy",   rr_in_ready,  3'b000);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel_rdy", rr_in_ready, 3'b010);
        tick();
        check("bp_rel_valid", rr_out_valid, 1);
        check("bp_rel_sel",   rr_out_sel,   1);
        check("bp_rel_data",  rr_out_data,  32'hB);

        // 5. Reset mid-stream with an item held and the pointer at 2.
        in_valid = 3'b111;
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", rr_out_valid, 0);
        check("mid_rst_sel",   rr_out_sel,   0);
        check("mid_rst_data",  rr_out_data,  0);
        tick();
        reset_n = 1'b1;
        #1;
        check("post_rst_rdy", rr_in_ready, 3'b001);
        tick();
        check("post_rst_sel",  rr_out_sel,  0);
        check("post_rst_data", rr_out_data, 32'hA);

        // Drain with no new request: valid drops, payload holds.
        in_valid = '0;
        tick();
        check("drain_valid", rr_out_valid, 0);
        check("drain_data",  rr_out_data,  32'hA);
        check("drain_sel",   rr_out_sel,   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_arb_mux_n
